// File: rtl/frame_packer.sv
// Serial-to-parallel frame packer: collects DATA_NUM samples into one wide frame
// with valid/ready on both sides. Optional running max: FRAME_PACKER_RUNMAX_EN.
module frame_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_NUM   = 16,
   parameter int IDX_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_valid,
   input  logic [DATA_WIDTH-1:0]          s_data,
   output logic                           s_ready,
   input  logic                           abort,
   output logic                           m_valid,
   output logic [DATA_WIDTH*DATA_NUM-1:0] m_data,
   input  logic                           m_ready,
`ifdef FRAME_PACKER_RUNMAX_EN
   output logic [DATA_WIDTH-1:0]          m_max,
   output logic [IDX_WIDTH-1:0]           m_max_num,
`endif
   output logic [IDX_WIDTH:0]             fill_count
);

   localparam int FRAME_W = DATA_WIDTH * DATA_NUM;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_NUM - 1);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                 state_r;
   logic [IDX_WIDTH-1:0]   wr_idx_r;
   logic [IDX_WIDTH:0]     fill_count_r;
   logic                   m_valid_r;
   logic [FRAME_W-1:0]     m_data_r;
   logic                   accept_s;
   logic                   handoff_s;
`ifdef FRAME_PACKER_RUNMAX_EN
   logic [DATA_WIDTH-1:0]  max_r;
   logic [IDX_WIDTH-1:0]   max_num_r;
`endif

   // Upstream handshake; abort blocks acceptance so an aborted sample is never consumed.
   assign s_ready   = (state_r == FILL) && !abort && !rst;
   assign accept_s  = s_valid && s_ready;
   assign handoff_s = m_valid_r && m_ready;

   assign m_valid    = m_valid_r;
   assign m_data     = m_data_r;
   assign fill_count = fill_count_r;
`ifdef FRAME_PACKER_RUNMAX_EN
   assign m_max      = max_r;
   assign m_max_num  = max_num_r;
`endif

   // Fill/hold state machine with registered frame, count and valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= FILL;
         wr_idx_r     <= {IDX_WIDTH{1'b0}};
         fill_count_r <= {(IDX_WIDTH+1){1'b0}};
         m_valid_r    <= 1'b0;
         m_data_r     <= {FRAME_W{1'b0}};
`ifdef FRAME_PACKER_RUNMAX_EN
         max_r        <= {DATA_WIDTH{1'b0}};
         max_num_r    <= {IDX_WIDTH{1'b0}};
`endif
      end else begin
         case (state_r)
            FILL: begin
               if (abort) begin
                  // Old lanes stay in m_data; they are simply overwritten by the next frame.
                  wr_idx_r     <= {IDX_WIDTH{1'b0}};
                  fill_count_r <= {(IDX_WIDTH+1){1'b0}};
`ifdef FRAME_PACKER_RUNMAX_EN
                  max_r        <= {DATA_WIDTH{1'b0}};
                  max_num_r    <= {IDX_WIDTH{1'b0}};
`endif
               end else if (accept_s) begin
                  m_data_r[DATA_WIDTH*int'(wr_idx_r) +: DATA_WIDTH] <= s_data;
                  fill_count_r <= fill_count_r + {{IDX_WIDTH{1'b0}}, 1'b1};
`ifdef FRAME_PACKER_RUNMAX_EN
                  // Strictly-greater update keeps the lowest index on ties.
                  if (wr_idx_r == {IDX_WIDTH{1'b0}}) begin
                     max_r     <= s_data;
                     max_num_r <= {IDX_WIDTH{1'b0}};
                  end else if (s_data > max_r) begin
                     max_r     <= s_data;
                     max_num_r <= wr_idx_r;
                  end else begin
                     max_r     <= max_r;
                     max_num_r <= max_num_r;
                  end
`endif
                  if (wr_idx_r == LAST_IDX) begin
                     wr_idx_r  <= {IDX_WIDTH{1'b0}};
                     m_valid_r <= 1'b1;
                     state_r   <= FULL;
                  end else begin
                     wr_idx_r  <= wr_idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                  end
               end else begin
                  wr_idx_r <= wr_idx_r;
               end
            end
            FULL: begin
               if (handoff_s) begin
                  m_valid_r    <= 1'b0;
                  fill_count_r <= {(IDX_WIDTH+1){1'b0}};
                  state_r      <= FILL;
               end else begin
                  m_valid_r    <= 1'b1;
               end
            end
            default: begin
               state_r      <= FILL;
               wr_idx_r     <= {IDX_WIDTH{1'b0}};
               fill_count_r <= {(IDX_WIDTH+1){1'b0}};
               m_valid_r    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_packer.sv
// Directed self-checking bench for frame_packer (default 8-bit x 16 lanes).
module tb_frame_packer;

   localparam int DW = 8;
   localparam int DN = 16;
   localparam int IW = 8;
   localparam int FW = DW * DN;

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          abort;
   logic          m_valid;
   logic [FW-1:0] m_data;
   logic          m_ready;
   logic [IW:0]   fill_count;
`ifdef FRAME_PACKER_RUNMAX_EN
   logic [DW-1:0] m_max;
   logic [IW-1:0] m_max_num;
`endif

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] lanes [DN];
   logic [FW-1:0] exp_frame;
   logic [FW-1:0] held;

   frame_packer #(.DATA_WIDTH(DW), .DATA_NUM(DN), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .abort(abort), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
`ifdef FRAME_PACKER_RUNMAX_EN
      .m_max(m_max), .m_max_num(m_max_num),
`endif
      .fill_count(fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FW-1:0] pack_lanes();
      logic [FW-1:0] f;
      f = {FW{1'b0}};
      for (int i = 0; i < DN; i++) f[DW*i +: DW] = lanes[i];
      return f;
   endfunction

   // Sends lanes[0..DN-1] back to back; m_valid must stay low until the last accept.
   task automatic send_frame(input string tag);
      for (int i = 0; i < DN; i++) begin
         s_valid = 1'b1;
         s_data  = lanes[i];
         tick();
         if (i < DN - 1) check({tag, "_mvalid_early"}, FW'(m_valid), FW'(1'b0));
      end
      s_valid = 1'b0;
      check({tag, "_mvalid"}, FW'(m_valid), FW'(1'b1));
      check({tag, "_frame"}, m_data, pack_lanes());
      check({tag, "_sready_full"}, FW'(s_ready), FW'(1'b0));
      check({tag, "_fill_full"}, FW'(fill_count), FW'(16));
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; abort = 1'b0; m_ready = 1'b0;
      // 1: reset
      tick(); tick(); tick();
      check("rst_sready", FW'(s_ready), FW'(1'b0));
      check("rst_mvalid", FW'(m_valid), FW'(1'b0));
      check("rst_mdata", m_data, {FW{1'b0}});
      check("rst_fill", FW'(fill_count), FW'(0));
      rst = 1'b0;
      #1;
      check("post_rst_sready", FW'(s_ready), FW'(1'b1));

      // 2: incrementing frame, m_ready already high
      m_ready = 1'b1;
      for (int i = 0; i < DN; i++) lanes[i] = DW'(i);
      send_frame("inc");
`ifdef FRAME_PACKER_RUNMAX_EN
      check("inc_max", FW'(m_max), FW'(8'h0F));
      check("inc_maxnum", FW'(m_max_num), FW'(15));
`endif
      tick();
      check("inc_drop_mvalid", FW'(m_valid), FW'(1'b0));
      check("inc_drop_fill", FW'(fill_count), FW'(0));

      // 3: held frame with back-pressure
      m_ready = 1'b0;
      for (int i = 0; i < DN; i++) lanes[i] = DW'(8'h10 + i);
      send_frame("hold");
      held = pack_lanes();
      s_valid = 1'b1; s_data = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("hold_mvalid", FW'(m_valid), FW'(1'b1));
         check("hold_mdata", m_data, held);
         check("hold_sready", FW'(s_ready), FW'(1'b0));
         check("hold_fill", FW'(fill_count), FW'(16));
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("hold_abort_ignored", m_data, held);
      check("hold_abort_mvalid", FW'(m_valid), FW'(1'b1));
      s_valid = 1'b0; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("hold_release_mvalid", FW'(m_valid), FW'(1'b0));
      check("hold_release_fill", FW'(fill_count), FW'(0));
      exp_frame = held;

      // 4: partial frame of 7, abort with s_valid high, then clean frame
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_data = DW'(8'h77 + i);
         exp_frame[DW*i +: DW] = DW'(8'h77 + i);
         tick();
      end
      check("part_fill", FW'(fill_count), FW'(7));
      check("part_lanes", m_data, exp_frame);
      s_data = 8'h99; abort = 1'b1;
      #1;
      check("abort_sready", FW'(s_ready), FW'(1'b0));
      tick();
      abort = 1'b0; s_valid = 1'b0;
      check("abort_fill", FW'(fill_count), FW'(0));
      check("abort_mdata", m_data, exp_frame);
      check("abort_mvalid", FW'(m_valid), FW'(1'b0));
`ifdef FRAME_PACKER_RUNMAX_EN
      check("abort_max", FW'(m_max), FW'(0));
      check("abort_maxnum", FW'(m_max_num), FW'(0));
`endif
      for (int i = 0; i < DN; i++) lanes[i] = DW'(8'hA0 + i);
      send_frame("after_abort");
`ifdef FRAME_PACKER_RUNMAX_EN
      check("aa_max", FW'(m_max), FW'(8'hAF));
      check("aa_maxnum", FW'(m_max_num), FW'(15));
`endif
      m_ready = 1'b1;
      tick();
      check("aa_release", FW'(m_valid), FW'(1'b0));

      // 5: tie between lanes 3 and 9
      for (int i = 0; i < DN; i++) lanes[i] = 8'h55;
      lanes[3] = 8'hF0;
      lanes[9] = 8'hF0;
      m_ready = 1'b0;
      send_frame("tie");
`ifdef FRAME_PACKER_RUNMAX_EN
      check("tie_max", FW'(m_max), FW'(8'hF0));
      check("tie_maxnum", FW'(m_max_num), FW'(3));
`endif
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("tie_release", FW'(m_valid), FW'(1'b0));

      // 6: reset mid-fill
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = DW'(8'h30 + i);
         tick();
      end
      check("mid_fill", FW'(fill_count), FW'(10));
      s_valid = 1'b0; rst = 1'b1;
      tick();
      check("midrst_fill", FW'(fill_count), FW'(0));
      check("midrst_mvalid", FW'(m_valid), FW'(1'b0));
      check("midrst_mdata", m_data, {FW{1'b0}});
      rst = 1'b0;
      for (int i = 0; i < DN; i++) lanes[i] = DW'(8'hC0 + i);
      send_frame("post_midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
